// File: rtl/module_data_memory_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// A (CPU) and B (loader/debug) share it; bursts are capped at MAX_BURST.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request, write flag, address, data
//   a_gnt                      port A accepted this cycle (combinational)
//   a_rvalid/a_rdata           port A read response, cycle after grant
//   b_*                        same for port B
//   mem_wr_en/mem_addr         memory write enable and word address
//   mem_data_in/mem_data_out   memory write data and registered read data
module module_data_memory_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int MAX_BURST    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDRESS_BITS-1:0] a_addr,
  input  logic [WORD_SIZE-1:0]    a_wdata,
  output logic                    a_gnt,
  output logic                    a_rvalid,
  output logic [WORD_SIZE-1:0]    a_rdata,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDRESS_BITS-1:0] b_addr,
  input  logic [WORD_SIZE-1:0]    b_wdata,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  output logic [WORD_SIZE-1:0]    b_rdata,
  output logic                    mem_wr_en,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]    mem_data_in,
  input  logic [WORD_SIZE-1:0]    mem_data_out
);

  localparam int CW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CAP =
    CW'(MAX_BURST - 1);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  owner_e        last_owner;
  logic [CW-1:0] burst_cnt;
  // run: the previous edge carried a grant, so
  // last_owner is mid-burst and may continue.
  logic          run;

  logic          keep;
  logic          pick_b;
  logic          any_gnt;
  owner_e        winner;

  always_comb begin
    keep   = run && (burst_cnt < CAP);
    pick_b = 1'b0;
    unique case (1'b1)
      (a_req && !b_req): pick_b = 1'b0;
      (!a_req && b_req): pick_b = 1'b1;
      (a_req && b_req):
        pick_b = keep ? (last_owner == OWN_B)
                      : (last_owner == OWN_A);
      default: pick_b = 1'b0;
    endcase
  end

  assign a_gnt   = rst_n && a_req && !pick_b;
  assign b_gnt   = rst_n && b_req && pick_b;
  assign any_gnt = a_gnt || b_gnt;
  assign winner  = b_gnt ? OWN_B : OWN_A;

  // With no grant the mux rests on port A.
  always_comb begin
    mem_wr_en   = (a_gnt && a_we) ||
                  (b_gnt && b_we);
    mem_addr    = '0;
    mem_data_in = '0;
    if (rst_n) begin
      mem_addr    = b_gnt ? b_addr : a_addr;
      mem_data_in = b_gnt ? b_wdata : a_wdata;
    end
  end

  assign a_rdata = mem_data_out;
  assign b_rdata = mem_data_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_B;
      burst_cnt  <= '0;
      run        <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (any_gnt) begin
        if (run && (winner == last_owner)) begin
          if (burst_cnt != CAP)
            burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= '0;
        end
        last_owner <= winner;
        run        <= 1'b1;
      end else begin
        burst_cnt <= '0;
        run       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_module_data_memory_arbiter.sv
// Self-checking bench for module_data_memory_arbiter.
// Random traffic against a grant/memory reference model.
module tb_module_data_memory_arbiter;

  localparam int WS = 32;
  localparam int AB = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AB-1:0] a_addr, b_addr;
  logic [WS-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt;
  logic          a_rvalid, b_rvalid;
  logic [WS-1:0] a_rdata, b_rdata;
  logic          mem_wr_en;
  logic [AB-1:0] mem_addr;
  logic [WS-1:0] mem_data_in;
  logic [WS-1:0] mem_data_out;
  logic          mem_clr;

  always #5 clk = ~clk;

  module_data_memory_arbiter #(
    .WORD_SIZE(WS),
    .ADDRESS_BITS(AB),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a_req(a_req),
    .a_we(a_we),
    .a_addr(a_addr),
    .a_wdata(a_wdata),
    .a_gnt(a_gnt),
    .a_rvalid(a_rvalid),
    .a_rdata(a_rdata),
    .b_req(b_req),
    .b_we(b_we),
    .b_addr(b_addr),
    .b_wdata(b_wdata),
    .b_gnt(b_gnt),
    .b_rvalid(b_rvalid),
    .b_rdata(b_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Environment memory: registered read, old data on read+write.
  logic [WS-1:0] env_mem [0:255];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= '0;
    end else begin
      if (mem_wr_en) env_mem[mem_addr[7:0]] <= mem_data_in;
      mem_data_out <= env_mem[mem_addr[7:0]];
    end
  end

  // Reference model: memory contents, owner and current streak length.
  logic [WS-1:0] refmem [0:255];
  int m_last;
  int m_streak;

  int checks = 0;
  int failures = 0;

  logic [1:0]    o_rv, e_rv;
  logic [WS-1:0] o_rd, e_rd;

  // 0 none, 1 A, 2 B
  function automatic int pick(bit ar, bit br);
    if (ar && !br) return 1;
    if (br && !ar) return 2;
    if (!ar && !br) return 0;
    if (m_streak >= 1 && m_streak < MB)
      return m_last + 1;
    return (m_last == 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_streak = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive at negedge, sample grant/mux at +1,
  // sample read response at the following negedge.
  task automatic cyc(
    input bit ar, input bit aw,
    input logic [AB-1:0] aa, input logic [WS-1:0] ad,
    input bit br, input bit bw,
    input logic [AB-1:0] ba, input logic [WS-1:0] bd,
    output int got, output int expw,
    output bit mux_ok, output bit rd_ok);
    bit we;
    logic [AB-1:0] ad_x;
    logic [WS-1:0] dt;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    expw = pick(ar, br);
    got = int'({b_gnt, a_gnt});
    mux_ok =
      (mem_wr_en === ((expw == 1) ? aw : (expw == 2) ? bw : 1'b0)) &&
      (mem_addr === ((expw == 2) ? ba : aa)) &&
      (mem_data_in === ((expw == 2) ? bd : ad));
    e_rv = 2'b00;
    e_rd = '0;
    if (expw != 0) begin
      we   = (expw == 1) ? aw : bw;
      ad_x = (expw == 1) ? aa : ba;
      dt   = (expw == 1) ? ad : bd;
      if (we) refmem[ad_x[7:0]] = dt;
      else begin
        e_rv = (expw == 1) ? 2'b01 : 2'b10;
        e_rd = refmem[ad_x[7:0]];
      end
      if (expw - 1 == m_last && m_streak > 0) m_streak++;
      else m_streak = 1;
      m_last = expw - 1;
    end else begin
      m_streak = 0;
    end
    @(posedge clk);
    @(negedge clk);
    o_rv = {b_rvalid, a_rvalid};
    o_rd = a_rvalid ? a_rdata : b_rdata;
    rd_ok = (o_rv === e_rv) && (e_rv == 2'b00 || o_rd === e_rd);
  endtask

  task automatic test_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5; a_wdata = 32'h1234;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'd9; b_wdata = 32'h55;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      failures++;
      $display("FAIL reset_gnt got=%b want=00", {a_gnt, b_gnt});
    end
    checks++;
    if (mem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_wr_en got=%b want=0", mem_wr_en);
    end
    checks++;
    if (mem_addr !== '0 || mem_data_in !== '0) begin
      failures++;
      $display("FAIL reset_mux got=%h/%h want=0/0", mem_addr, mem_data_in);
    end
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_rvalid got=%b want=00", {a_rvalid, b_rvalid});
    end
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_read();
    int g, e;
    bit mo, ro;
    cyc(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, g, e, mo, ro);
    do_reset();
    cyc(1, 0, 5, 0, 0, 0, 0, 0, g, e, mo, ro);
    checks++;
    if (g !== 1) begin
      failures++;
      $display("FAIL single_gnt got=%0d want=1", g);
    end
    checks++;
    if (o_rv !== 2'b01 || o_rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_rdata got=%b/%h want=01/deadbeef", o_rv, o_rd);
    end
    checks++;
    if (!mo) begin
      failures++;
      $display("FAIL single_mux got=%h want=5", mem_addr);
    end
  endtask

  task automatic test_burst();
    int g, e, want, wa, wb, maxw;
    bit mo, ro;
    do_reset();
    wa = 0; wb = 0; maxw = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, $urandom_range(0, 15), 0,
          1, 0, $urandom_range(0, 15), 0, g, e, mo, ro);
      want = (((i / MB) % 2) == 0) ? 1 : 2;
      checks++;
      if (g !== want || g !== e) begin
        failures++;
        $display("FAIL burst_seq[%0d] got=%0d want=%0d model=%0d", i, g, want, e);
      end
      checks++;
      if (!ro) begin
        failures++;
        $display("FAIL burst_rd[%0d] got=%b/%h want=%b/%h", i, o_rv, o_rd, e_rv, e_rd);
      end
      wa = (g == 1) ? 0 : wa + 1;
      wb = (g == 2) ? 0 : wb + 1;
      if (wa > maxw) maxw = wa;
      if (wb > maxw) maxw = wb;
    end
    checks++;
    if (maxw > MB) begin
      failures++;
      $display("FAIL burst_fair got=%0d want<=%0d", maxw, MB);
    end
  endtask

  task automatic test_write_read();
    int g, e;
    bit mo, ro;
    cyc(1, 1, 3, 7, 0, 0, 0, 0, g, e, mo, ro);
    cyc(0, 0, 0, 0, 1, 0, 3, 0, g, e, mo, ro);
    checks++;
    if (o_rv !== 2'b10 || o_rd !== 32'd7) begin
      failures++;
      $display("FAIL wr_rd got=%b/%h want=10/7", o_rv, o_rd);
    end
    cyc(1, 0, 3, 0, 0, 0, 0, 0, g, e, mo, ro);
    cyc(1, 1, 3, 8, 0, 0, 0, 0, g, e, mo, ro);
    cyc(1, 0, 3, 0, 0, 0, 0, 0, g, e, mo, ro);
    checks++;
    if (o_rd !== 32'd8 || !ro) begin
      failures++;
      $display("FAIL b2b_new got=%h want=8", o_rd);
    end
    do_reset();
    cyc(1, 1, 3, 9, 1, 0, 3, 0, g, e, mo, ro);
    checks++;
    if (g !== 1 || !mo) begin
      failures++;
      $display("FAIL same_cycle_gnt got=%0d want=1", g);
    end
    cyc(0, 0, 0, 0, 1, 0, 3, 0, g, e, mo, ro);
    checks++;
    if (o_rv !== 2'b10 || o_rd !== 32'd9) begin
      failures++;
      $display("FAIL same_cycle_rd got=%b/%h want=10/9", o_rv, o_rd);
    end
  endtask

  task automatic test_reset_mid_read();
    int g, e;
    bit mo, ro;
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd3;
    b_req = 1'b0;
    #1;
    checks++;
    if (a_gnt !== 1'b1) begin
      failures++;
      $display("FAIL mid_gnt got=%b want=1", a_gnt);
    end
    @(posedge clk);
    #2;
    checks++;
    if (a_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_rvalid_pre got=%b want=1", a_rvalid);
    end
    rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    checks++;
    if (a_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rvalid_drop got=%b want=0", a_rvalid);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL mid_rvalid_after got=%b want=00", {a_rvalid, b_rvalid});
    end
    @(negedge clk);
    model_reset();
    cyc(1, 0, 1, 0, 1, 0, 2, 0, g, e, mo, ro);
    checks++;
    if (g !== 1 || g !== e) begin
      failures++;
      $display("FAIL mid_first_gnt got=%0d want=1", g);
    end
  endtask

  task automatic test_b_only();
    int g, e, waited;
    bit mo, ro, seen;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 1, $urandom_range(0, 1),
          $urandom_range(0, 15), $urandom, g, e, mo, ro);
      checks++;
      if (g !== 2 || !mo || !ro) begin
        failures++;
        $display("FAIL b_only[%0d] got=%0d want=2 mux=%b rd=%b", i, g, mo, ro);
      end
    end
    waited = 0;
    seen = 1'b0;
    for (int i = 0; i < MB + 2 && !seen; i++) begin
      cyc(1, 0, 4, 0, 1, 0, 5, 0, g, e, mo, ro);
      waited++;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL b_then_a[%0d] got=%0d want=%0d", i, g, e);
      end
      if (g == 1) seen = 1'b1;
    end
    checks++;
    if (!seen || waited > MB) begin
      failures++;
      $display("FAIL a_latency got=%0d want<=%0d", waited, MB);
    end
  endtask

  task automatic test_random();
    int g, e;
    bit mo, ro;
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom % 4) != 0, $urandom_range(0, 1),
          $urandom_range(0, 15), $urandom,
          ($urandom % 4) != 0, $urandom_range(0, 1),
          $urandom_range(0, 15), $urandom, g, e, mo, ro);
      checks++;
      if (g !== e || !mo) begin
        failures++;
        $display("FAIL rand_gnt[%0d] got=%0d want=%0d mux=%b", i, g, e, mo);
      end
      checks++;
      if (!ro) begin
        failures++;
        $display("FAIL rand_rd[%0d] got=%b/%h want=%b/%h", i, o_rv, o_rd, e_rv, e_rd);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    mem_clr = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 256; i++) refmem[i] = '0;
    model_reset();
    #2;
    test_reset();
    test_single_read();
    test_burst();
    test_write_read();
    test_reset_mid_read();
    test_b_only();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
